// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// The optional performance counters (ICACHE_PERF_EN) use sat_inc.
package icache_pkg;

    localparam int          LINE_WORDS = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill sequencer: IDLE/REFILL FSM, beat counter, line base latch and the
// flag that stops a refill from being marked valid if fence.i arrived during it.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_i,
    input  logic [27:0] line_i,
    input  logic        invalidate_i,
    input  logic        mem_valid_i,
    output state_e      state_o,
    output logic [27:0] base_o,
    output logic [1:0]  beat_o,
    output logic        beat_we_o,
    output logic        line_done_o,
    output logic        line_valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o
);

    state_e      state_q, state_d;
    logic [27:0] base_q, base_d;
    logic [1:0]  beat_q, beat_d;
    logic        cancel_q, cancel_d;
    logic        last_beat;

    assign last_beat = (beat_q == 2'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            beat_q   <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        beat_d   = beat_q;
        cancel_d = cancel_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_i) begin
                    state_d  = ST_REFILL;
                    base_d   = line_i;
                    beat_d   = '0;
                    cancel_d = 1'b0;
                end
            end
            ST_REFILL: begin
                if (invalidate_i) cancel_d = 1'b1;
                if (mem_valid_i) begin
                    beat_d = beat_q + 2'd1;
                    if (last_beat) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request and address stay stable for the whole beat until memory accepts it.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        beat_we_o    = 1'b0;
        line_done_o  = 1'b0;
        line_valid_o = 1'b0;
        if (state_q == ST_REFILL) begin
            mem_req_o    = 1'b1;
            mem_addr_o   = {base_q, beat_q, 2'b00};
            beat_we_o    = mem_valid_i;
            line_done_o  = mem_valid_i && last_beat;
            line_valid_o = mem_valid_i && last_beat && !cancel_q && !invalidate_i;
        end
    end

    assign state_o = state_q;
    assign base_o  = base_q;
    assign beat_o  = beat_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, 16-byte lines, combinational lookup.
// Define ICACHE_PERF_EN to add saturating hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        invalidate_i,
    output logic [31:0] instr_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    logic [IDX_W-1:0] idx, base_idx;
    logic [TAG_W-1:0] tag, base_tag;
    logic [1:0]       off, beat;
    logic [27:0]      base;
    state_e           state;
    logic             hit, miss, beat_we, line_done, line_valid;
    logic             unused_addr_bits;

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][LINE_WORDS];

    assign off              = addr_i[3:2];
    assign idx              = addr_i[4 +: IDX_W];
    assign tag              = addr_i[31 -: TAG_W];
    assign unused_addr_bits = ^addr_i[1:0];
    assign base_idx         = base[IDX_W-1:0];
    assign base_tag         = base[27 -: TAG_W];

    icache_refill_ctrl u_refill_ctrl (
        .clk          (clk),
        .rst          (rst),
        .miss_i       (miss),
        .line_i       (addr_i[31:4]),
        .invalidate_i (invalidate_i),
        .mem_valid_i  (mem_valid_i),
        .state_o      (state),
        .base_o       (base),
        .beat_o       (beat),
        .beat_we_o    (beat_we),
        .line_done_o  (line_done),
        .line_valid_o (line_valid),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o)
    );

    assign hit     = (state == ST_IDLE) && valid_q[idx] && (tag_mem[idx] == tag);
    assign miss    = (state == ST_IDLE) && !hit;
    assign instr_o = hit ? data_mem[idx][off] : NOP_INSTR;
    assign stall_o = !hit;

    // The victim line is dropped as soon as its refill starts, so an abandoned
    // or cancelled burst can never expose a half-written line.
    always_comb begin
        valid_d = valid_q;
        if (miss) valid_d[idx] = 1'b0;
        if (line_valid) valid_d[base_idx] = 1'b1;
        if (invalidate_i) valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (beat_we)   data_mem[base_idx][beat] <= mem_rdata_i;
        if (line_done) tag_mem[base_idx]        <= base_tag;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
        miss_cnt_d = miss ? sat_inc(miss_cnt_q) : miss_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a line-level reference model; the
// bench itself plays backing memory (word at address a = 0xA0 + a/4).
module tb_icache;
    import icache_pkg::*;

    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic        invalidate_i = 1'b0;
    logic [31:0] instr_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    icache #(.SETS(SETS)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .invalidate_i (invalidate_i),
        .instr_o      (instr_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
`ifdef ICACHE_PERF_EN
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
`endif
        .mem_valid_i  (mem_valid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          model_valid [SETS];
    logic [31:0] model_tag   [SETS];
    int          model_hits   = 0;
    int          model_misses = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + {2'b00, a[31:2]};
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[4 +: IDX_W]);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (4 + IDX_W);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return model_valid[idx_of(a)] && (model_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) model_valid[i] = 1'b0;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        rst          = 1'b0;
        invalidate_i = 1'b0;
        mem_valid_i  = 1'b0;
        mem_rdata_i  = $urandom;
    endtask

    // mode 0: memory always ready, 1: ready every other cycle, 2: random.
    // inv_beat 0..3 pulses fence.i on that beat of the first refill.
    task automatic fetch(input logic [31:0] a, input int mode, input int inv_beat, input bit jitter);
        int          since_miss;
        bit          cancel;
        bit          got;
        bit          first_clean;
        logic [31:0] ea;
        since_miss  = -1;
        first_clean = (mode == 0) && (inv_beat > 3);
        for (int t = 0; t < 4; t++) begin
            begin_cycle();
            addr_i      = a;
            mem_valid_i = 1'($urandom_range(0, 1));
            #1;
            if (since_miss >= 0) since_miss++;
            if (model_hit(a)) begin
                checks++;
                if (stall_o !== 1'b0 || instr_o !== mem_word(a) || mem_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL hit %h: stall=%b instr=%h req=%b, want stall=0 instr=%h req=0",
                             a, stall_o, instr_o, mem_req_o, mem_word(a));
                end
                if (first_clean && t == 1) begin
                    checks++;
                    if (since_miss != 5) begin
                        errors++;
                        $display("FAIL miss_latency %h: hit %0d cycles after miss, want 5", a, since_miss);
                    end
                end
                model_hits++;
                return;
            end
            checks++;
            if (stall_o !== 1'b1 || instr_o !== NOP_INSTR || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL miss %h: stall=%b instr=%h req=%b, want stall=1 instr=%h req=0",
                         a, stall_o, instr_o, mem_req_o, NOP_INSTR);
            end
            model_misses++;
            since_miss = 0;
            model_valid[idx_of(a)] = 1'b0;
            cancel = 1'b0;
            for (int b = 0; b < 4; b++) exp_q.push_back({a[31:4], 2'(b), 2'b00});
            while (exp_q.size() > 0) begin
                ea  = exp_q[0];
                got = 1'b0;
                for (int w = 0; w < 8 && !got; w++) begin
                    begin_cycle();
                    addr_i = jitter ? $urandom : a;
                    if (t == 0 && w == 0 && inv_beat == int'(ea[3:2])) begin
                        invalidate_i = 1'b1;
                        cancel       = 1'b1;
                        model_clear();
                    end
                    got = (mode == 0) || (mode == 1 && (w % 2) == 1) ||
                          (mode == 2 && $urandom_range(0, 1) == 1) || (w == 7);
                    mem_valid_i = got;
                    if (got) mem_rdata_i = mem_word(ea);
                    #1;
                    since_miss++;
                    checks++;
                    if (mem_req_o !== 1'b1 || mem_addr_o !== ea || stall_o !== 1'b1 || instr_o !== NOP_INSTR) begin
                        errors++;
                        $display("FAIL refill_beat %h: req=%b addr=%h stall=%b instr=%h, want req=1 addr=%h stall=1 instr=%h",
                                 a, mem_req_o, mem_addr_o, stall_o, instr_o, ea, NOP_INSTR);
                    end
                end
                void'(exp_q.pop_front());
            end
            if (!cancel) begin
                model_valid[idx_of(a)] = 1'b1;
                model_tag[idx_of(a)]   = tag_of(a);
            end
        end
        checks++;
        errors++;
        $display("FAIL fetch %h: no hit after 4 lookups", a);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst          = 1'b1;
        addr_i       = '0;
        invalidate_i = 1'b0;
        mem_valid_i  = 1'b1;
        mem_rdata_i  = $urandom;
        #1;
        checks++;
        if (stall_o !== 1'b1 || instr_o !== NOP_INSTR || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: stall=%b instr=%h req=%b addr=%h, want 1 %h 0 0",
                     stall_o, instr_o, mem_req_o, mem_addr_o, NOP_INSTR);
        end
        model_clear();
        model_hits   = 0;
        model_misses = 0;
`ifdef ICACHE_PERF_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, want 0 0", hit_cnt_o, miss_cnt_o);
        end
`endif
    endtask

    task automatic test_basic();
        fetch(32'h0, 0, 7, 0);
        fetch(32'h8, 0, 7, 0);
        fetch(32'h4, 0, 7, 0);
        begin_cycle();
        addr_i = 32'hC;
        #1;
        checks++;
        if (stall_o !== 1'b0 || instr_o !== 32'hA3 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_hit_c: stall=%b instr=%h req=%b, want 0 000000a3 0", stall_o, instr_o, mem_req_o);
        end
`ifdef ICACHE_PERF_EN
        checks++;
        if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd3) begin
            errors++;
            $display("FAIL perf_basic: miss=%0d hit=%0d, want 1 3", miss_cnt_o, hit_cnt_o);
        end
`endif
        model_hits++;
    endtask

    task automatic test_replace();
        fetch(32'h100, 1, 7, 0);
        fetch(32'h0, 0, 7, 0);
        fetch(32'h108, 2, 7, 1);
    endtask

    task automatic test_invalidate_refill();
        fetch(32'h20, 0, 2, 0);
        fetch(32'h2C, 1, 3, 1);
    endtask

    task automatic test_invalidate_idle(input logic [31:0] a);
        fetch(a, 0, 7, 0);
        begin_cycle();
        addr_i       = a;
        invalidate_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || instr_o !== mem_word(a)) begin
            errors++;
            $display("FAIL inv_idle_hit %h: stall=%b instr=%h, want 0 %h", a, stall_o, instr_o, mem_word(a));
        end
        model_hits++;
        model_clear();
        fetch(a, 0, 7, 0);
    endtask

    task automatic test_reset_mid(input logic [31:0] a);
        begin_cycle();
        addr_i = a;
        #1;
        checks++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_miss %h: stall=%b req=%b, want 1 0", a, stall_o, mem_req_o);
        end
        for (int b = 0; b < 2; b++) begin
            begin_cycle();
            addr_i      = a;
            mem_valid_i = 1'b1;
            mem_rdata_i = mem_word({a[31:4], 2'(b), 2'b00});
        end
        begin_cycle();
        addr_i = a;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== {a[31:4], 4'h8}) begin
            errors++;
            $display("FAIL rst_mid_beat2 %h: req=%b addr=%h, want 1 %h", a, mem_req_o, mem_addr_o, {a[31:4], 4'h8});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || stall_o !== 1'b1 || instr_o !== NOP_INSTR) begin
            errors++;
            $display("FAIL rst_mid_abort: req=%b addr=%h stall=%b instr=%h, want 0 0 1 %h",
                     mem_req_o, mem_addr_o, stall_o, instr_o, NOP_INSTR);
        end
        model_clear();
        model_hits   = 0;
        model_misses = 0;
        fetch(a, 0, 7, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
            case ($urandom_range(0, 9))
                0:       fetch(a, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
                1:       test_invalidate_idle(a);
                default: fetch(a, $urandom_range(0, 2), 7, 1'($urandom_range(0, 1)));
            endcase
        end
    endtask

    task automatic test_perf_counters();
`ifdef ICACHE_PERF_EN
        fetch(32'h0, 0, 7, 0);
        begin_cycle();
        addr_i = 32'h0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || hit_cnt_o !== 32'(model_hits) || miss_cnt_o !== 32'(model_misses)) begin
            errors++;
            $display("FAIL perf_counters: stall=%b hit=%0d miss=%0d, want 0 %0d %0d",
                     stall_o, hit_cnt_o, miss_cnt_o, model_hits, model_misses);
        end
        model_hits++;
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_replace();
        test_invalidate_refill();
        test_invalidate_idle(32'h24);
        test_reset_mid(32'h340);
        test_random();
        test_perf_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SETS, 16, number of direct-mapped lines; power of two, 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 addr_i  input  32  fetch PC; bits [1:0] ignored.
REQ-005 invalidate_i  input  1  fence.i request; clears all lines.
REQ-006 instr_o  output  32  instruction word for addr_i on hit; 32'h00000013 (nop) otherwise.
REQ-007 stall_o  output  1  high while instr_o does not hold the instruction for addr_i; drives fetch stall.
REQ-008 mem_req_o  output  1  refill beat request to backing memory.
REQ-009 mem_addr_o  output  32  word address of requested beat.
REQ-010 mem_valid_i  input  1  backing memory beat accepted, data valid.
REQ-011 mem_rdata_i  input  32  beat data.

Function
REQ-012 The line SHALL be 4 words (16 bytes); offset = addr_i[3:2], index = addr_i[3+log2(SETS):4], tag = remaining upper bits.
REQ-013 Lookup SHALL be combinational: hit = state IDLE, valid[index], stored tag == tag; on hit instr_o = data[index][offset], stall_o = 0, same cycle.
REQ-014 FSM states SHALL be IDLE and REFILL only.
REQ-015 IDLE with miss: stall_o = 1, instr_o = nop; at next edge latch line base (addr_i[31:4]), beat = 0, enter REFILL.
REQ-016 REFILL: mem_req_o = 1, mem_addr_o = {base, beat, 2'b00}, stall_o = 1, instr_o = nop; both address and request held stable until mem_valid_i.
REQ-017 Each edge with mem_valid_i = 1 in REFILL SHALL write mem_rdata_i into data[base index][beat] and increment beat (2-bit, wraps 3->0).
REQ-018 On the edge accepting beat 3: write tag, set valid (unless cancelled per REQ-020), return to IDLE.
REQ-019 Minimum miss penalty with mem_valid_i constantly high: miss cycle + 4 beats; hit on cycle 5 after miss detection.
REQ-020 invalidate_i in IDLE: all valid bits clear at next edge. invalidate_i in REFILL: valid bits clear, burst completes, refilled line NOT marked valid.
REQ-021 addr_i changing during REFILL SHALL NOT alter the burst; lookup re-evaluates against the new addr_i on return to IDLE.
REQ-022 mem_valid_i in IDLE SHALL be ignored.
REQ-023 Refill overwrites any previously valid line at the same index (no replacement choice).

Reset
REQ-024 rst SHALL immediately force: state IDLE, all valid bits 0, beat 0, mem_req_o 0, mem_addr_o 0, counters 0; data/tag arrays need not reset.
REQ-025 Reset mid-REFILL SHALL abandon the burst; partially written line remains invalid.
REQ-026 Outputs during reset: stall_o 1 (miss), instr_o nop.

Configuration
REQ-027 Macro ICACHE_PERF_EN defined: 32-bit outputs hit_cnt_o and miss_cnt_o SHALL exist; hit_cnt_o increments per cycle with hit; miss_cnt_o per IDLE->REFILL transition; both saturate at 32'hFFFFFFFF.
REQ-028 ICACHE_PERF_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package icache_pkg SHALL hold the state enum, LINE_WORDS = 4, NOP_INSTR = 32'h00000013.
REQ-030 Sub-module icache_refill_ctrl SHALL contain the FSM, beat counter, base-address latch and invalidate-cancel flag; arrays and lookup stay in icache.

Verification
REQ-031 Reset, addr_i = 0x0, memory returns 0xA0,0xA1,0xA2,0xA3 with mem_valid_i always high -> mem_addr_o 0x0,0x4,0x8,0xC; stall_o low on cycle 5; instr_o = 0xA0.
REQ-032 After REQ-031, addr_i = 0x8 -> instr_o = 0xA2, stall_o 0, no mem_req_o.
REQ-033 addr_i = 0x100 (SETS = 16, same index 0, new tag), mem_valid_i toggling every other cycle -> address held between beats; line 0 replaced; 0x0 then misses.
REQ-034 invalidate_i pulsed during beat 2 of refill -> burst completes, return to IDLE, same address misses again.
REQ-035 rst asserted after beat 1 -> mem_req_o 0 immediately; after release, same address misses and refills from beat 0.
REQ-036 ICACHE_PERF_EN defined, REQ-031 then 3 hit cycles -> miss_cnt_o = 1, hit_cnt_o = 3.
